// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - core sizing constants and BRU op encoding shared by the BRU pipeline
package core_types_pkg;

    localparam int LOG_PR_COUNT       = 7;
    localparam int LOG_ROB_ENTRIES    = 6;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;

    typedef enum logic [3:0] {
        BRU_JALR   = 4'b0000,
        BRU_C_JALR = 4'b0001,
        BRU_JAL    = 4'b0010,
        BRU_C_JAL  = 4'b0011,
        BRU_C_J    = 4'b0100,
        BRU_C_JR   = 4'b0101,
        BRU_LUI    = 4'b0110,
        BRU_AUIPC  = 4'b0111,
        BRU_BEQ    = 4'b1000,
        BRU_BNE    = 4'b1001,
        BRU_C_BEQZ = 4'b1010,
        BRU_C_BNEZ = 4'b1011,
        BRU_BLT    = 4'b1100,
        BRU_BGE    = 4'b1101,
        BRU_BLTU   = 4'b1110,
        BRU_BGEU   = 4'b1111
    } bru_op_t;

    // One bit per op encoding: set for the 16-bit (compressed) forms
    localparam logic [15:0] BRU_COMPRESSED_MASK = 16'h0C3A;

    typedef struct packed {
        logic [3:0]                 op;
        logic [31:0]                pc;
        logic [31:0]                spec;
        logic [31:0]                imm;
        logic [LOG_PR_COUNT-1:0]    dest;
        logic [LOG_ROB_ENTRIES-1:0] rob;
    } bru_uop_t;

    function automatic logic bru_is_compressed(input logic [3:0] op);
        return BRU_COMPRESSED_MASK[op];
    endfunction

endpackage

// File: rtl/bru_resolve.sv
// rtl/bru_resolve.sv - combinational next-PC and writeback value for one BRU op
module bru_resolve
    import core_types_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] next_pc,
    output logic [31:0] wb_data
);

    bru_op_t     op_e;
    logic [31:0] link;
    logic [31:0] rel_target;
    logic [31:0] cmp_b;
    logic        taken;

    assign op_e = bru_op_t'(op);

    always_comb begin
        link       = pc + (bru_is_compressed(op) ? 32'd2 : 32'd4);
        rel_target = pc + imm;
        cmp_b      = (op_e == BRU_C_BEQZ || op_e == BRU_C_BNEZ) ? 32'd0 : b;
        taken      = 1'b0;
        next_pc    = link;
        wb_data    = link;
        case (op_e)
            BRU_BEQ, BRU_C_BEQZ: taken = (a == cmp_b);
            BRU_BNE, BRU_C_BNEZ: taken = (a != cmp_b);
            BRU_BLT:             taken = ($signed(a) < $signed(cmp_b));
            BRU_BGE:             taken = ($signed(a) >= $signed(cmp_b));
            BRU_BLTU:            taken = (a < cmp_b);
            BRU_BGEU:            taken = (a >= cmp_b);
            default:             taken = 1'b0;
        endcase
        case (op_e)
            BRU_JALR, BRU_C_JALR, BRU_C_JR: next_pc = (a + imm) & ~32'd1;
            BRU_JAL, BRU_C_JAL, BRU_C_J:    next_pc = rel_target;
            BRU_LUI:                        wb_data = imm;
            BRU_AUIPC:                      wb_data = rel_target;
            default:                        next_pc = taken ? rel_target : link;
        endcase
    end

endmodule

// File: rtl/bru_pipeline.sv
// rtl/bru_pipeline.sv - BRU OC/EX/WB pipeline; BRU_PERF_COUNTERS_EN adds branch/restart counters
module bru_pipeline
    import core_types_pkg::*;
(
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              issue_valid,
    input  logic [3:0]                        issue_op,
    input  logic [31:0]                       issue_PC,
    input  logic [31:0]                       issue_speculated_next_PC,
    input  logic [31:0]                       issue_imm,
    input  logic                              issue_A_unneeded,
    input  logic                              issue_A_forward,
    input  logic [LOG_PRF_BANK_COUNT-1:0]     issue_A_bank,
    input  logic                              issue_B_unneeded,
    input  logic                              issue_B_forward,
    input  logic [LOG_PRF_BANK_COUNT-1:0]     issue_B_bank,
    input  logic [LOG_PR_COUNT-1:0]           issue_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0]        issue_ROB_index,
    output logic                              pipeline_ready,
    input  logic                              PRF_resp_A_valid,
    input  logic                              PRF_resp_B_valid,
    input  logic [31:0]                       PRF_resp_A_data,
    input  logic [31:0]                       PRF_resp_B_data,
    input  logic [PRF_BANK_COUNT-1:0][31:0]   forward_data_by_bank,
    output logic                              WB_valid,
    output logic [31:0]                       WB_data,
    output logic [LOG_PR_COUNT-1:0]           WB_PR,
    output logic [LOG_ROB_ENTRIES-1:0]        WB_ROB_index,
    input  logic                              WB_ready,
    output logic                              restart_valid,
    output logic [31:0]                       restart_PC,
    output logic [LOG_ROB_ENTRIES-1:0]        restart_ROB_index
`ifdef BRU_PERF_COUNTERS_EN
    ,
    output logic [31:0]                       perf_branch_count,
    output logic [31:0]                       perf_restart_count
`endif
);

    bru_uop_t                    oc_uop_q, oc_uop_d, ex_uop_q, ex_uop_d;
    logic                        oc_valid_q, oc_valid_d, oc_first_q, oc_first_d;
    logic                        oc_a_fwd_q, oc_a_fwd_d, oc_b_fwd_q, oc_b_fwd_d;
    logic [LOG_PRF_BANK_COUNT-1:0] oc_a_bank_q, oc_a_bank_d, oc_b_bank_q, oc_b_bank_d;
    logic                        oc_a_have_q, oc_a_have_d, oc_b_have_q, oc_b_have_d;
    logic [31:0]                 oc_a_data_q, oc_a_data_d, oc_b_data_q, oc_b_data_d;
    logic                        ex_valid_q, ex_valid_d;
    logic [31:0]                 ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic                        wb_valid_q, wb_valid_d;
    logic [31:0]                 wb_data_q, wb_data_d;
    logic [LOG_PR_COUNT-1:0]     wb_pr_q, wb_pr_d;
    logic [LOG_ROB_ENTRIES-1:0]  wb_rob_q, wb_rob_d;
    logic                        restart_valid_q, restart_valid_d;
    logic [31:0]                 restart_pc_q, restart_pc_d;
    logic [LOG_ROB_ENTRIES-1:0]  restart_rob_q, restart_rob_d;
`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0]                 perf_branch_q, perf_branch_d, perf_restart_q, perf_restart_d;
`endif

    logic        fwd_a, fwd_b, a_ready, b_ready;
    logic [31:0] a_value, b_value;
    logic        accept, oc_advance, ex_advance, ex_xfer;
    logic [31:0] ex_next_pc, ex_wb_data;

    bru_resolve u_resolve (
        .op      (ex_uop_q.op),
        .pc      (ex_uop_q.pc),
        .imm     (ex_uop_q.imm),
        .a       (ex_a_q),
        .b       (ex_b_q),
        .next_pc (ex_next_pc),
        .wb_data (ex_wb_data)
    );

    always_comb begin
        // Forward data is only meaningful in the first OC cycle and beats a PRF response
        fwd_a      = oc_first_q & oc_a_fwd_q;
        fwd_b      = oc_first_q & oc_b_fwd_q;
        a_ready    = oc_a_have_q | fwd_a | PRF_resp_A_valid;
        b_ready    = oc_b_have_q | fwd_b | PRF_resp_B_valid;
        a_value    = fwd_a ? forward_data_by_bank[oc_a_bank_q] :
                     oc_a_have_q ? oc_a_data_q : PRF_resp_A_data;
        b_value    = fwd_b ? forward_data_by_bank[oc_b_bank_q] :
                     oc_b_have_q ? oc_b_data_q : PRF_resp_B_data;
        ex_advance = ~wb_valid_q | WB_ready;
        ex_xfer    = ex_valid_q & ex_advance;
        oc_advance = oc_valid_q & a_ready & b_ready & (~ex_valid_q | ex_advance);
        pipeline_ready = ~oc_valid_q | oc_advance;
        accept     = issue_valid & pipeline_ready;

        oc_valid_d  = accept | (oc_valid_q & ~oc_advance);
        oc_uop_d    = oc_uop_q;
        oc_first_d  = 1'b0;
        oc_a_fwd_d  = oc_a_fwd_q;
        oc_b_fwd_d  = oc_b_fwd_q;
        oc_a_bank_d = oc_a_bank_q;
        oc_b_bank_d = oc_b_bank_q;
        oc_a_have_d = oc_a_have_q | a_ready;
        oc_b_have_d = oc_b_have_q | b_ready;
        oc_a_data_d = oc_a_have_q ? oc_a_data_q : a_value;
        oc_b_data_d = oc_b_have_q ? oc_b_data_q : b_value;
        if (accept) begin
            oc_uop_d    = '{op: issue_op, pc: issue_PC, spec: issue_speculated_next_PC,
                            imm: issue_imm, dest: issue_dest_PR, rob: issue_ROB_index};
            oc_first_d  = 1'b1;
            oc_a_fwd_d  = issue_A_forward;
            oc_b_fwd_d  = issue_B_forward;
            oc_a_bank_d = issue_A_bank;
            oc_b_bank_d = issue_B_bank;
            oc_a_have_d = issue_A_unneeded;
            oc_b_have_d = issue_B_unneeded;
        end

        ex_valid_d = oc_advance | (ex_valid_q & ~ex_advance);
        ex_uop_d   = oc_advance ? oc_uop_q : ex_uop_q;
        ex_a_d     = oc_advance ? a_value : ex_a_q;
        ex_b_d     = oc_advance ? b_value : ex_b_q;

        wb_valid_d = ex_xfer | (wb_valid_q & ~WB_ready);
        wb_data_d  = ex_xfer ? ex_wb_data : wb_data_q;
        wb_pr_d    = ex_xfer ? (ex_uop_q.op[3] ? '0 : ex_uop_q.dest) : wb_pr_q;
        wb_rob_d   = ex_xfer ? ex_uop_q.rob : wb_rob_q;

        restart_valid_d = ex_xfer & (ex_next_pc != ex_uop_q.spec);
        restart_pc_d    = restart_valid_d ? ex_next_pc : restart_pc_q;
        restart_rob_d   = restart_valid_d ? ex_uop_q.rob : restart_rob_q;
`ifdef BRU_PERF_COUNTERS_EN
        perf_branch_d  = perf_branch_q + {31'd0, ex_xfer & ex_uop_q.op[3]};
        perf_restart_d = perf_restart_q + {31'd0, restart_valid_q};
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            oc_valid_q      <= 1'b0;
            oc_uop_q        <= '0;
            oc_first_q      <= 1'b0;
            oc_a_fwd_q      <= 1'b0;
            oc_b_fwd_q      <= 1'b0;
            oc_a_bank_q     <= '0;
            oc_b_bank_q     <= '0;
            oc_a_have_q     <= 1'b0;
            oc_b_have_q     <= 1'b0;
            oc_a_data_q     <= '0;
            oc_b_data_q     <= '0;
            ex_valid_q      <= 1'b0;
            ex_uop_q        <= '0;
            ex_a_q          <= '0;
            ex_b_q          <= '0;
            wb_valid_q      <= 1'b0;
            wb_data_q       <= '0;
            wb_pr_q         <= '0;
            wb_rob_q        <= '0;
            restart_valid_q <= 1'b0;
            restart_pc_q    <= '0;
            restart_rob_q   <= '0;
`ifdef BRU_PERF_COUNTERS_EN
            perf_branch_q   <= '0;
            perf_restart_q  <= '0;
`endif
        end else begin
            oc_valid_q      <= oc_valid_d;
            oc_uop_q        <= oc_uop_d;
            oc_first_q      <= oc_first_d;
            oc_a_fwd_q      <= oc_a_fwd_d;
            oc_b_fwd_q      <= oc_b_fwd_d;
            oc_a_bank_q     <= oc_a_bank_d;
            oc_b_bank_q     <= oc_b_bank_d;
            oc_a_have_q     <= oc_a_have_d;
            oc_b_have_q     <= oc_b_have_d;
            oc_a_data_q     <= oc_a_data_d;
            oc_b_data_q     <= oc_b_data_d;
            ex_valid_q      <= ex_valid_d;
            ex_uop_q        <= ex_uop_d;
            ex_a_q          <= ex_a_d;
            ex_b_q          <= ex_b_d;
            wb_valid_q      <= wb_valid_d;
            wb_data_q       <= wb_data_d;
            wb_pr_q         <= wb_pr_d;
            wb_rob_q        <= wb_rob_d;
            restart_valid_q <= restart_valid_d;
            restart_pc_q    <= restart_pc_d;
            restart_rob_q   <= restart_rob_d;
`ifdef BRU_PERF_COUNTERS_EN
            perf_branch_q   <= perf_branch_d;
            perf_restart_q  <= perf_restart_d;
`endif
        end
    end

    assign WB_valid          = wb_valid_q;
    assign WB_data           = wb_data_q;
    assign WB_PR             = wb_pr_q;
    assign WB_ROB_index      = wb_rob_q;
    assign restart_valid     = restart_valid_q;
    assign restart_PC        = restart_pc_q;
    assign restart_ROB_index = restart_rob_q;
`ifdef BRU_PERF_COUNTERS_EN
    assign perf_branch_count  = perf_branch_q;
    assign perf_restart_count = perf_restart_q;
`endif

endmodule

// File: tb/tb_bru_pipeline.sv
// tb/tb_bru_pipeline.sv - randomized and directed bench for bru_pipeline against an ISA-level model
`timescale 1ns/1ps
module tb_bru_pipeline;
    import core_types_pkg::*;

    logic CLK = 1'b0, RST = 1'b1;
    logic issue_valid = 1'b0;
    logic [3:0] issue_op = '0;
    logic [31:0] issue_PC = '0, issue_speculated_next_PC = '0, issue_imm = '0;
    logic issue_A_unneeded = 1'b0, issue_A_forward = 1'b0, issue_B_unneeded = 1'b0, issue_B_forward = 1'b0;
    logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank = '0, issue_B_bank = '0;
    logic [LOG_PR_COUNT-1:0] issue_dest_PR = '0;
    logic [LOG_ROB_ENTRIES-1:0] issue_ROB_index = '0;
    logic pipeline_ready;
    logic PRF_resp_A_valid = 1'b0, PRF_resp_B_valid = 1'b0;
    logic [31:0] PRF_resp_A_data = '0, PRF_resp_B_data = '0;
    logic [PRF_BANK_COUNT-1:0][31:0] forward_data_by_bank = '0;
    logic WB_valid, WB_ready = 1'b1, restart_valid;
    logic [31:0] WB_data, restart_PC;
    logic [LOG_PR_COUNT-1:0] WB_PR;
    logic [LOG_ROB_ENTRIES-1:0] WB_ROB_index, restart_ROB_index;
`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] perf_branch_count, perf_restart_count;
`endif

    bru_pipeline dut (
        .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_PC(issue_PC), .issue_speculated_next_PC(issue_speculated_next_PC), .issue_imm(issue_imm),
        .issue_A_unneeded(issue_A_unneeded), .issue_A_forward(issue_A_forward), .issue_A_bank(issue_A_bank),
        .issue_B_unneeded(issue_B_unneeded), .issue_B_forward(issue_B_forward), .issue_B_bank(issue_B_bank),
        .issue_dest_PR(issue_dest_PR), .issue_ROB_index(issue_ROB_index), .pipeline_ready(pipeline_ready),
        .PRF_resp_A_valid(PRF_resp_A_valid), .PRF_resp_B_valid(PRF_resp_B_valid),
        .PRF_resp_A_data(PRF_resp_A_data), .PRF_resp_B_data(PRF_resp_B_data),
        .forward_data_by_bank(forward_data_by_bank), .WB_valid(WB_valid), .WB_data(WB_data),
        .WB_PR(WB_PR), .WB_ROB_index(WB_ROB_index), .WB_ready(WB_ready),
        .restart_valid(restart_valid), .restart_PC(restart_PC), .restart_ROB_index(restart_ROB_index)
`ifdef BRU_PERF_COUNTERS_EN
        , .perf_branch_count(perf_branch_count), .perf_restart_count(perf_restart_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] op;
        logic [31:0] pc, spec, imm, a, b;
        logic a_un, a_fw, a_both, b_un, b_fw;
        logic [LOG_PRF_BANK_COUNT-1:0] a_bank, b_bank;
        int a_dly, b_dly;
        logic [LOG_PR_COUNT-1:0] dest;
        logic [LOG_ROB_ENTRIES-1:0] rob;
    } top_t;

    top_t ops[$], exp_q[$], oc_op;
    int acc_q[$];
    int next_issue = 0, oc_cycle = 0, edge_n = 0, run_start = 0;
    int total = 0, bad = 0, m_branch = 0, m_restart = 0;
    logic oc_has = 1'b0, pre_valid = 1'b0, consumed = 1'b0, rdy = 1'b0, saw_not_ready = 1'b0;
    logic [31:0] h_data;
    logic [LOG_PR_COUNT-1:0] h_pr;
    logic [LOG_ROB_ENTRIES-1:0] h_rob;

    function automatic logic needs_a(input logic [3:0] op);
        return (op == 4'd0 || op == 4'd1 || op == 4'd5 || op >= 4'd8);
    endfunction
    function automatic logic needs_b(input logic [3:0] op);
        return (op >= 4'd8 && op != 4'd10 && op != 4'd11);
    endfunction
    function automatic logic [31:0] link_of(input top_t t);
        return t.pc + ((t.op inside {4'd1, 4'd3, 4'd4, 4'd5, 4'd10, 4'd11}) ? 32'd2 : 32'd4);
    endfunction
    function automatic logic [31:0] model_next(input top_t t);
        logic [31:0] bb;
        logic taken;
        bb = (t.op == 4'd10 || t.op == 4'd11) ? 32'd0 : t.b;
        case (t.op)
            4'd0, 4'd1, 4'd5: return (t.a + t.imm) & 32'hFFFF_FFFE;
            4'd2, 4'd3, 4'd4: return t.pc + t.imm;
            4'd8, 4'd10: taken = (t.a == bb);
            4'd9, 4'd11: taken = (t.a != bb);
            4'd12: taken = ($signed(t.a) < $signed(bb));
            4'd13: taken = !($signed(t.a) < $signed(bb));
            4'd14: taken = (t.a < bb);
            4'd15: taken = !(t.a < bb);
            default: return link_of(t);
        endcase
        return taken ? t.pc + t.imm : link_of(t);
    endfunction
    function automatic logic [31:0] model_data(input top_t t);
        if (t.op == 4'd6) return t.imm;
        if (t.op == 4'd7) return t.pc + t.imm;
        return link_of(t);
    endfunction
    function automatic int need_of(input top_t t);
        int n = 0;
        if (!t.a_un && !t.a_fw) n = t.a_dly;
        if (!t.b_un && !t.b_fw && t.b_dly > n) n = t.b_dly;
        return n;
    endfunction
    function automatic top_t mk(input logic [3:0] op, input logic [31:0] pc, spec, imm, a, b,
                                input logic [LOG_PR_COUNT-1:0] dest, input logic [LOG_ROB_ENTRIES-1:0] rob);
        top_t t;
        t.op = op; t.pc = pc; t.spec = spec; t.imm = imm; t.a = a; t.b = b; t.dest = dest; t.rob = rob;
        t.a_un = !needs_a(op); t.a_fw = needs_a(op); t.a_both = 1'b0; t.a_bank = 0; t.a_dly = 0;
        t.b_un = !needs_b(op); t.b_fw = needs_b(op); t.b_bank = 1; t.b_dly = 0;
        return t;
    endfunction
    function automatic top_t rand_op();
        top_t t;
        t = mk(4'($urandom_range(15)), $urandom, 32'd0, $urandom, $urandom, $urandom,
               LOG_PR_COUNT'($urandom), LOG_ROB_ENTRIES'($urandom));
        if ($urandom_range(1) == 0) t.imm = 32'($urandom_range(255)) - 32'd128;
        if ($urandom_range(3) == 0) t.b = t.a;
        t.a_un = needs_a(t.op) ? 1'b0 : 1'($urandom_range(1));
        t.b_un = needs_b(t.op) ? 1'b0 : 1'($urandom_range(1));
        t.a_fw = !t.a_un && $urandom_range(1) == 1;
        t.b_fw = !t.b_un && $urandom_range(1) == 1;
        t.a_both = t.a_fw && $urandom_range(1) == 1;
        t.a_bank = LOG_PRF_BANK_COUNT'($urandom); t.b_bank = LOG_PRF_BANK_COUNT'($urandom);
        t.a_dly = $urandom_range(3); t.b_dly = $urandom_range(3);
        if (t.a_fw && t.b_fw && t.a_bank == t.b_bank) t.b = t.a;
        t.spec = ($urandom_range(1) == 1) ? model_next(t) : $urandom;
        return t;
    endfunction

    task automatic run_ops(input int gap_pct, input int hold, input int ready_pct,
                           input logic lat_mode, input int stop_after);
        int cyc = 0;
        logic new_item, exp_rs;
        logic [31:0] exp_np;
        top_t e;
        int acc;
        saw_not_ready = 1'b0;
        run_start = edge_n;
        while (!(next_issue >= ops.size() && !oc_has && exp_q.size() == 0)) begin
            if (stop_after > 0 && cyc >= stop_after) break;
            if (cyc >= 3000) begin
                total++; bad++;
                $display("FAIL run_budget got=%0d pending required=0", exp_q.size());
                break;
            end
            @(negedge CLK);
            for (int k = 0; k < PRF_BANK_COUNT; k++) forward_data_by_bank[k] = $urandom;
            PRF_resp_A_valid = 1'b0; PRF_resp_A_data = $urandom;
            PRF_resp_B_valid = 1'b0; PRF_resp_B_data = $urandom;
            if (oc_has) begin
                if (oc_cycle == 0) begin
                    if (oc_op.a_fw) forward_data_by_bank[oc_op.a_bank] = oc_op.a;
                    if (oc_op.b_fw) forward_data_by_bank[oc_op.b_bank] = oc_op.b;
                    if (oc_op.a_both) begin PRF_resp_A_valid = 1'b1; PRF_resp_A_data = ~oc_op.a; end
                end
                if (!oc_op.a_un && !oc_op.a_fw && oc_cycle == oc_op.a_dly) begin
                    PRF_resp_A_valid = 1'b1; PRF_resp_A_data = oc_op.a;
                end
                if (!oc_op.b_un && !oc_op.b_fw && oc_cycle == oc_op.b_dly) begin
                    PRF_resp_B_valid = 1'b1; PRF_resp_B_data = oc_op.b;
                end
            end
            issue_valid = 1'b0;
            if (next_issue < ops.size() && $urandom_range(99) >= gap_pct) begin
                e = ops[next_issue];
                issue_valid = 1'b1; issue_op = e.op; issue_PC = e.pc;
                issue_speculated_next_PC = e.spec; issue_imm = e.imm;
                issue_A_unneeded = e.a_un; issue_A_forward = e.a_fw; issue_A_bank = e.a_bank;
                issue_B_unneeded = e.b_un; issue_B_forward = e.b_fw; issue_B_bank = e.b_bank;
                issue_dest_PR = e.dest; issue_ROB_index = e.rob;
            end
            WB_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
            #1;
            rdy = pipeline_ready;
            pre_valid = WB_valid;
            consumed = WB_valid & WB_ready;
            if (!rdy) saw_not_ready = 1'b1;
            if (lat_mode) begin
                total++;
                if (rdy !== (!oc_has || oc_cycle >= need_of(oc_op))) begin
                    bad++;
                    $display("FAIL pipeline_ready got=%b required=%b", rdy, !oc_has || oc_cycle >= need_of(oc_op));
                end
            end
            @(posedge CLK);
            edge_n++;
            if (rdy) begin
                if (issue_valid) begin
                    oc_op = ops[next_issue]; oc_has = 1'b1; oc_cycle = 0;
                    exp_q.push_back(ops[next_issue]); acc_q.push_back(edge_n);
                    next_issue++;
                end else oc_has = 1'b0;
            end else oc_cycle++;
            #1;
            new_item = WB_valid && (!pre_valid || consumed);
            if (pre_valid && !consumed) begin
                total++;
                if (WB_valid !== 1'b1 || WB_data !== h_data || WB_PR !== h_pr || WB_ROB_index !== h_rob) begin
                    bad++;
                    $display("FAIL wb_hold got=%b/%h/%0d/%0d required=1/%h/%0d/%0d",
                             WB_valid, WB_data, WB_PR, WB_ROB_index, h_data, h_pr, h_rob);
                end
            end
            if (new_item && exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wb_extra got=WB_valid required=no_op");
            end else if (new_item) begin
                e = exp_q.pop_front(); acc = acc_q.pop_front();
                exp_np = model_next(e); exp_rs = (exp_np != e.spec);
                total++;
                if (WB_PR !== (e.op >= 4'd8 ? '0 : e.dest) || WB_ROB_index !== e.rob) begin
                    bad++;
                    $display("FAIL wb_tag got=%0d/%0d required=%0d/%0d", WB_PR, WB_ROB_index,
                             (e.op >= 4'd8 ? 0 : e.dest), e.rob);
                end
                if (e.op < 4'd8) begin
                    total++;
                    if (WB_data !== model_data(e)) begin
                        bad++;
                        $display("FAIL wb_data op=%0d got=%h required=%h", e.op, WB_data, model_data(e));
                    end
                end
                total++;
                if (restart_valid !== exp_rs) begin
                    bad++;
                    $display("FAIL restart_valid op=%0d got=%b required=%b", e.op, restart_valid, exp_rs);
                end else if (exp_rs) begin
                    total++;
                    if (restart_PC !== exp_np || restart_ROB_index !== e.rob) begin
                        bad++;
                        $display("FAIL restart_pc got=%h/%0d required=%h/%0d", restart_PC,
                                 restart_ROB_index, exp_np, e.rob);
                    end
                end
                if (lat_mode && acc >= run_start) begin
                    total++;
                    if (edge_n - acc != 2 + need_of(e)) begin
                        bad++;
                        $display("FAIL latency got=%0d required=%0d", edge_n - acc, 2 + need_of(e));
                    end
                end
                if (e.op >= 4'd8) m_branch++;
                if (exp_rs) m_restart++;
            end else begin
                total++;
                if (restart_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL restart_spurious got=%b required=0", restart_valid);
                end
            end
            h_data = WB_data; h_pr = WB_PR; h_rob = WB_ROB_index;
            cyc++;
        end
        issue_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        total++;
        if (pipeline_ready !== 1'b1 || WB_valid !== 1'b0 || WB_data !== '0 || WB_PR !== '0 ||
            WB_ROB_index !== '0 || restart_valid !== 1'b0 || restart_PC !== '0 || restart_ROB_index !== '0) begin
            bad++;
            $display("FAIL %s got=rdy%b wbv%b %h %0d %0d rv%b %h %0d required=rdy1 all_zero", tag,
                     pipeline_ready, WB_valid, WB_data, WB_PR, WB_ROB_index, restart_valid, restart_PC, restart_ROB_index);
        end
`ifdef BRU_PERF_COUNTERS_EN
        total++;
        if (perf_branch_count !== '0 || perf_restart_count !== '0) begin
            bad++;
            $display("FAIL %s_perf got=%0d/%0d required=0/0", tag, perf_branch_count, perf_restart_count);
        end
`endif
    endtask

    task automatic check_perf();
`ifdef BRU_PERF_COUNTERS_EN
        total++;
        if (perf_branch_count !== 32'(m_branch) || perf_restart_count !== 32'(m_restart)) begin
            bad++;
            $display("FAIL perf got=%0d/%0d required=%0d/%0d", perf_branch_count, perf_restart_count,
                     m_branch, m_restart);
        end
`endif
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check_idle_outputs("reset_state");
        @(negedge CLK) RST = 1'b0;
    endtask

    task automatic test_beq_forward();
        top_t t = mk(4'd8, 32'h100, 32'h104, 32'h20, 32'h55, 32'h55, 7'd9, 6'd1);
        t.a_bank = 2; t.b_bank = 3;
        ops.push_back(t);
        run_ops(0, 0, 100, 1'b1, 0);
    endtask

    task automatic test_jal();
        ops.push_back(mk(4'd2, 32'h200, 32'h240, 32'h40, 32'h0, 32'h0, 7'd5, 6'd2));
        run_ops(0, 0, 100, 1'b1, 0);
    endtask

    task automatic test_jalr_late();
        top_t t = mk(4'd0, 32'h500, 32'h2000, 32'h0, 32'h1001, 32'h0, 7'd3, 6'd3);
        t.a_fw = 1'b0; t.a_dly = 4;
        ops.push_back(t);
        run_ops(0, 0, 100, 1'b1, 0);
        total++;
        if (saw_not_ready !== 1'b1) begin
            bad++;
            $display("FAIL jalr_wait_ready got=%b required=1", saw_not_ready);
        end
    endtask

    task automatic test_back_to_back();
        ops.push_back(mk(4'd2, 32'h600, 32'h0, 32'h10, 32'h0, 32'h0, 7'd7, 6'd4));
        ops.push_back(mk(4'd9, 32'h610, 32'h614, 32'h8, 32'h1, 32'h2, 7'd8, 6'd5));
        ops.push_back(mk(4'd7, 32'h620, 32'h624, 32'h1000, 32'h0, 32'h0, 7'd9, 6'd6));
        run_ops(0, 5, 100, 1'b0, 0);
        total++;
        if (saw_not_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_ready got=%b required=1", saw_not_ready);
        end
    endtask

    task automatic test_compare();
        top_t t;
        ops.push_back(mk(4'd14, 32'h400, 32'h410, 32'h10, 32'hFFFF_FFFF, 32'h1, 7'd1, 6'd7));
        ops.push_back(mk(4'd12, 32'h400, 32'h404, 32'h10, 32'hFFFF_FFFF, 32'h1, 7'd1, 6'd8));
        t = mk(4'd11, 32'h300, 32'h302, 32'h40, 32'h0, 32'h7, 7'd1, 6'd9);
        t.a_fw = 1'b0; t.a_dly = 1;
        ops.push_back(t);
        run_ops(0, 0, 100, 1'b1, 0);
    endtask

    task automatic test_random();
        repeat (150) ops.push_back(rand_op());
        run_ops(30, 0, 70, 1'b0, 0);
        repeat (60) ops.push_back(rand_op());
        run_ops(20, 0, 100, 1'b1, 0);
        check_perf();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 4; i++) ops.push_back(mk(4'd6, 32'h700 + 32'(i), 32'h0, 32'h1234 + 32'(i), 0, 0, 7'd2, 6'(i)));
        run_ops(0, 100, 100, 1'b0, 6);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_idle_outputs("reset_midflight");
        ops.delete(); exp_q.delete(); acc_q.delete();
        next_issue = 0; oc_has = 1'b0; m_branch = 0; m_restart = 0;
        @(posedge CLK);
        #1 check_idle_outputs("reset_hold");
        @(negedge CLK) RST = 1'b0;
        WB_ready = 1'b1;
        repeat (30) ops.push_back(rand_op());
        run_ops(20, 0, 80, 1'b0, 0);
        check_perf();
    endtask

    initial begin
        test_reset();
        test_beq_forward();
        test_jal();
        test_jalr_late();
        test_back_to_back();
        test_compare();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
